// File: rtl/seq_serializer.sv
// Bit-serial transmitter: parallel words in over valid/ready, one bit per clock out.
// A one-word pending buffer lets consecutive words stream with no idle cycle between them.
module seq_serializer #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);
    // state | meaning
    // IDLE  | nothing to send, outputs held low
    // SHIFT | presenting one bit of sh per clock, cnt = bits left after this one
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    state_t           state, state_d;
    logic [WIDTH-1:0] sh, pend, sh_shifted;
    logic [CW-1:0]    cnt;
    logic             pend_full, accept, last_bit;
    logic             bit_d, valid_d, last_d;

    assign load_ready = !pend_full;
    assign accept     = load_valid && load_ready;
    assign last_bit   = (cnt == '0);
    assign busy       = (state == SHIFT) || pend_full;
    assign sh_shifted = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last_bit && !pend_full && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bit_d   = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (state == SHIFT) begin
            bit_d   = MSB_FIRST ? sh[WIDTH-1] : sh[0];
            valid_d = 1'b1;
            last_d  = last_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh        <= '0;
            pend      <= '0;
            cnt       <= '0;
            pend_full <= 1'b0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_bit   <= bit_d;
            out_valid <= valid_d;
            out_last  <= last_d;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh  <= load_data;
                        cnt <= CNT_TOP;
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        sh  <= sh_shifted;
                        cnt <= cnt - CW'(1);
                        if (accept) begin
                            pend      <= load_data;
                            pend_full <= 1'b1;
                        end
                    end else if (pend_full) begin
                        sh        <= pend;
                        pend_full <= 1'b0;
                        cnt       <= CNT_TOP;
                    end else if (accept) begin
                        // pend is empty on the final bit, so the new word goes straight in
                        sh  <= load_data;
                        cnt <= CNT_TOP;
                    end else begin
                        sh <= sh_shifted;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a bit-schedule model (each accepted word owns WIDTH slots).
module tb_seq_serializer;
    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         m_ready, m_bit, m_valid, m_last, m_busy;
    logic         l_ready, l_bit, l_valid, l_last, l_busy;

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(m_ready),
        .load_data(load_data), .out_bit(m_bit), .out_valid(m_valid),
        .out_last(m_last), .busy(m_busy)
    );

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(l_ready),
        .load_data(load_data), .out_bit(l_bit), .out_valid(l_valid),
        .out_last(l_last), .busy(l_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int   et;
        logic bm;
        logic bl;
        logic lst;
    } slot_t;

    slot_t q[$];
    int    t          = 0;
    int    tail_end   = 0;
    int    last_start = 0;
    int    n_assert   = 0;
    int    n_fail     = 0;
    int    v_cnt      = 0;
    int    l_cnt      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic schedule(input logic [W-1:0] d);
        int start;
        start = ((t > tail_end) ? t : tail_end) + 1;
        for (int i = 0; i < W; i++) begin
            slot_t e;
            e.et  = start + i;
            e.bm  = d[W-1-i];
            e.bl  = d[i];
            e.lst = (i == W - 1);
            q.push_back(e);
        end
        tail_end   = start + W - 1;
        last_start = start;
    endtask

    // One clock: predict the handshake, advance the model, then check both DUTs.
    task automatic step();
        logic  acc;
        logic  ev, ebm, ebl, elst;
        slot_t e;
        acc = load_valid && !reset && !(last_start > t + 1);
        @(posedge clk);
        t++;
        if (reset) begin
            q.delete();
            tail_end   = 0;
            last_start = 0;
        end else if (acc) begin
            schedule(load_data);
        end
        #1;
        ev = 1'b0; ebm = 1'b0; ebl = 1'b0; elst = 1'b0;
        if (q.size() > 0 && q[0].et == t) begin
            e    = q.pop_front();
            ev   = 1'b1;
            ebm  = e.bm;
            ebl  = e.bl;
            elst = e.lst;
        end
        chk("msb_valid", m_valid, ev);
        chk("msb_bit", m_bit, ebm);
        chk("msb_last", m_last, elst);
        chk("msb_ready", m_ready, !(last_start > t + 1));
        chk("msb_busy", m_busy, tail_end > t);
        chk("lsb_valid", l_valid, ev);
        chk("lsb_bit", l_bit, ebl);
        chk("lsb_last", l_last, elst);
        chk("lsb_ready", l_ready, !(last_start > t + 1));
        chk("lsb_busy", l_busy, tail_end > t);
        if (m_valid === 1'b1) v_cnt++;
        if (m_last === 1'b1) l_cnt++;
    endtask

    task automatic idle(input int n);
        load_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer(input logic [W-1:0] d);
        load_valid = 1'b1;
        load_data  = d;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        step();
        step();
        reset = 1'b0;
        idle(2);

        // single word
        v_cnt = 0; l_cnt = 0;
        offer(32'hD72DBEEF);
        idle(36);
        chk("single_valid_count", v_cnt, 32);
        chk("single_last_count", l_cnt, 1);

        // second word queued while the first shifts
        v_cnt = 0; l_cnt = 0;
        offer(32'hD72DBEEF);
        idle(3);
        offer(32'h00000001);
        chk("pend_ready_low", m_ready, 1'b0);
        idle(70);
        chk("pair_valid_count", v_cnt, 64);
        chk("pair_last_count", l_cnt, 2);

        // second word offered exactly on the final-bit cycle
        v_cnt = 0; l_cnt = 0;
        offer(32'hA5A5F00F);
        idle(W - 1);
        offer(32'h3C3C0FF1);
        idle(70);
        chk("bypass_valid_count", v_cnt, 64);
        chk("bypass_last_count", l_cnt, 2);

        // reset at bit 10 with a word pending
        offer(32'hD72DBEEF);
        offer(32'h12345678);
        idle(8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_busy", m_busy, 1'b0);
        chk("rst_ready", m_ready, 1'b1);
        v_cnt = 0;
        idle(70);
        chk("rst_no_pending", v_cnt, 0);

        // LSB-first instance sees 1,1,0,1 then zeros
        offer(32'h0000000B);
        idle(36);

        // random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            reset      = ($urandom_range(0, 149) == 0);
            load_valid = ($urandom_range(0, 2) != 0);
            load_data  = $urandom;
            step();
        end
        reset = 1'b0;
        idle(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_serializer.md
# seq_serializer

Bit-serial transmitter that converts parallel words into a one-bit-per-clock stream. It drives the `in` input of the `seq` Moore sequence detector, and of any other single-bit serial consumer, in RTL instead of from a testbench. It accepts words over a valid/ready handshake and buffers one pending word, so consecutive words stream with no idle cycle between them.

## Interface
- `WIDTH`, 32: word length in bits (≥2).
- `MSB_FIRST`, 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `load_valid`  input  1  `load_data` is offered.
- `load_ready`  output  1  a word can be accepted (combinational: `!pend_full`).
- `load_data`  input  WIDTH  word to transmit.
- `out_bit`  output  1  serial data (registered).
- `out_valid`  output  1  `out_bit` carries a real bit this cycle (registered).
- `out_last`  output  1  high with the final bit of each word (registered).
- `busy`  output  1  high in state SHIFT, or while the pending register is full.

## Operation
- Storage:
  - shift register `sh[WIDTH-1:0]`;
  - bit counter `cnt` of width clog2(WIDTH);
  - pending word register `pend` with flag `pend_full`.
- Accept: a word transfers on a rising edge where `load_valid && load_ready`.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - Outputs: `out_valid`=0, `out_last`=0, `out_bit`=0.
  - On accept: load `sh` with `load_data`, set `cnt`=WIDTH-1, go to SHIFT.
- SHIFT:
  - Each cycle, drive `out_bit` = `sh[WIDTH-1]` (MSB_FIRST=1) or `sh[0]` (MSB_FIRST=0), with `out_valid`=1.
  - Shift `sh` one position toward the output end, zero-filling, and decrement `cnt`.
  - `out_last`=1 when the bit being presented is the word's final bit (`cnt`=0).
- Accept during SHIFT:
  - The word goes to `pend` and `pend_full` is set.
  - Exception: on the cycle where `cnt`=0 and `pend_full`=0, the word bypasses `pend` and loads straight into `sh`.
- End of word (`cnt`=0), in priority order:
  1. `pend_full`: move `pend` into `sh`, clear `pend_full`, set `cnt`=WIDTH-1, stay in SHIFT.
  2. Otherwise, same-cycle accept: load `load_data` into `sh`, stay in SHIFT.
  3. Otherwise: go to IDLE.
- Simultaneous pend→sh move and new accept at `cnt`=0: impossible, because `load_ready`=0 while `pend_full`=1.
- The bit stream is continuous. Every bit of every accepted word is emitted exactly once, in order; there are no gaps while words are available.

## Timing
- Reset values:
  - `out_bit`=0, `out_valid`=0, `out_last`=0, `busy`=0;
  - `pend_full`=0, hence `load_ready`=1;
  - state IDLE, `cnt`=0, `sh`=0.
- Reset mid-word aborts the word and discards `pend`. Outputs are cleared on that same edge.
- Reset has priority over accept. A word offered on a reset edge is not taken.
- Latency:
  - Accept at edge N (from IDLE) → first bit valid from edge N+1.
  - Last bit valid from edge N+WIDTH; `out_valid` drops at edge N+WIDTH+1 if nothing is queued.
- Back-to-back: the first bit of the next word follows the previous `out_last` cycle directly (zero idle cycles).
- Throughput: one bit per clock. At most two words are held at once (one in `sh`, one in `pend`).
- `load_ready` may change only after a clock edge. It is asserted throughout IDLE and while `pend` is empty.

## Test plan
- Reset, then load `D72DBEEF` (WIDTH=32, MSB_FIRST=1) → from the next cycle, `out_bit` reads 1,1,0,1,0,1,1,1,0,0,1,0,… ending 1,1,1,1. `out_valid` is high for exactly 32 cycles; `out_last` is high only on the 32nd; then the block returns to IDLE with `busy`=0.
- Load `D72DBEEF`, then `00000001` while shifting → `load_ready` is 0 after the second accept. 64 contiguous valid bits are emitted: the final bit is 1 and bits 33–63 are 0. `out_last` pulses at bits 32 and 64.
- Offer word 2 exactly on the `cnt`=0 cycle with `pend` empty (bypass path) → no gap between words; the first bit of word 2 appears the cycle after word 1's `out_last`.
- Assert `reset` for one cycle at bit 10 of `D72DBEEF` with a word pending → on the next cycle, `out_valid`=0, `busy`=0, `load_ready`=1. The pending word is never emitted.
- MSB_FIRST=0, load `0000000B` → bits 1,1,0,1 followed by 28 zeros, with `out_last` on the 32nd.
- Feed the output into `seq` and compare the detector's `out` against its behaviour when driven bit-by-bit from a bench with the same pattern → identical `out` trace, shifted by the one-cycle serializer latency.
